// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer: releases N MLP layers from reset one at a time, in order.
// Each layer runs until its done rises. A per-layer watchdog, abort, a one-deep
// queued start and a saturating latency counter are included.
module mlp_layer_sequencer #(
  parameter int NUM_LAYERS     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16,
  parameter int LW             = $clog2(NUM_LAYERS)
) (
  input  logic                  clk_x70,
  input  logic                  reset_x70,
  input  logic                  start_x70,
  input  logic                  abort_x70,
  input  logic [NUM_LAYERS-1:0] layer_done_x70,
  output logic [NUM_LAYERS-1:0] layer_reset_x70,
  output logic [LW-1:0]         active_layer_x70,
  output logic                  busy_x70,
  output logic                  done_x70,
  output logic                  error_x70,
  output logic [CNT_W-1:0]      cycle_count_x70
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_FINISH = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t                r_state;
  logic [NUM_LAYERS-1:0] r_layer_reset;
  logic [LW-1:0]         r_active;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [CNT_W-1:0]      r_cycle_count;
  logic                  r_pending;
  logic [CNT_W-1:0]      r_timer;
  logic [CNT_W-1:0]      r_running;
  logic                  r_start_q;
  logic [NUM_LAYERS-1:0] r_done_q;

  logic                  w_start_rise;
  logic                  w_done_rise;
  logic                  w_last;
  logic                  w_timeout;
  logic [CNT_W-1:0]      w_running_inc;
  logic [NUM_LAYERS-1:0] w_release_mask;

  // Only the active layer's done edge matters; a level already high at release
  // is not an edge because the history register has already seen it.
  assign w_start_rise   = start_x70 & ~r_start_q;
  assign w_done_rise    = layer_done_x70[r_active] & ~r_done_q[r_active];
  assign w_last         = (r_active == LW'(NUM_LAYERS - 1));
  assign w_timeout      = (r_timer == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_running_inc  = (&r_running) ? r_running : r_running + 1'b1;
  assign w_release_mask = ~(NUM_LAYERS'(1) << r_active);

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk_x70 or posedge reset_x70) begin
    if (reset_x70) begin
      r_state       <= S_IDLE;
      r_layer_reset <= '1;
      r_active      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_cycle_count <= '0;
      r_pending     <= 1'b0;
      r_timer       <= '0;
      r_running     <= '0;
      r_start_q     <= 1'b0;
      r_done_q      <= '0;
    end else begin
      r_start_q <= start_x70;
      r_done_q  <= layer_done_x70;
      r_done    <= 1'b0;
      if (abort_x70) begin
        // Abort wins over everything; error and last latency are kept.
        r_state       <= S_IDLE;
        r_layer_reset <= '1;
        r_busy        <= 1'b0;
        r_pending     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_layer_reset <= '1;
            r_busy        <= 1'b0;
            if (w_start_rise) begin
              r_state   <= S_LAUNCH;
              r_active  <= '0;
              r_running <= '0;
              r_error   <= 1'b0;
              r_busy    <= 1'b1;
            end
          end
          S_LAUNCH: begin
            r_layer_reset <= w_release_mask;
            r_timer       <= '0;
            r_running     <= w_running_inc;
            r_state       <= S_RUN;
            if (w_start_rise) r_pending <= 1'b1;
          end
          S_RUN: begin
            r_running <= w_running_inc;
            r_timer   <= r_timer + 1'b1;
            if (w_start_rise) r_pending <= 1'b1;
            if (w_done_rise) begin
              r_layer_reset <= '1;
              if (w_last) begin
                r_state       <= S_FINISH;
                r_done        <= 1'b1;
                r_cycle_count <= w_running_inc;
              end else begin
                r_state  <= S_LAUNCH;
                r_active <= r_active + 1'b1;
              end
            end else if (w_timeout) begin
              // A failed inference does not leave a queued start behind.
              r_state       <= S_FAULT;
              r_layer_reset <= '1;
              r_error       <= 1'b1;
              r_busy        <= 1'b0;
              r_pending     <= 1'b0;
            end
          end
          S_FINISH: begin
            r_layer_reset <= '1;
            // A start arriving in this last busy cycle is served like a queued one.
            if (r_pending || w_start_rise) begin
              r_pending <= 1'b0;
              r_state   <= S_LAUNCH;
              r_active  <= '0;
              r_running <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          S_FAULT: begin
            r_layer_reset <= '1;
            r_busy        <= 1'b0;
            if (w_start_rise) begin
              r_state   <= S_LAUNCH;
              r_active  <= '0;
              r_running <= '0;
              r_error   <= 1'b0;
              r_busy    <= 1'b1;
            end
          end
          default: begin
            r_state       <= S_IDLE;
            r_layer_reset <= '1;
            r_busy        <= 1'b0;
          end
        endcase
      end
    end
  end

  assign layer_reset_x70  = r_layer_reset;
  assign active_layer_x70 = r_active;
  assign busy_x70         = r_busy;
  assign done_x70         = r_done;
  assign error_x70        = r_error;
  assign cycle_count_x70  = r_cycle_count;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Scoreboard bench for mlp_layer_sequencer (3 layers, 16-cycle watchdog).
// A responder plays the layers: it raises a layer's done a configured number of
// RUN cycles after that layer leaves reset.
module tb_mlp_layer_sequencer;
  localparam int NL  = 3;
  localparam int TO  = 16;
  localparam int CW  = 16;
  localparam int LWT = $clog2(NL);

  typedef struct {
    bit is_fault;
    int edge_c;
    int count;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NL-1:0] resp_done = '0;
  logic [NL-1:0] man_done = '0;
  logic [NL-1:0] layer_done;
  logic [NL-1:0] layer_reset;
  logic [LWT-1:0] active_layer;
  logic          busy, done, error;
  logic [CW-1:0] cycle_count;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   d_cfg [NL];
  int   rcnt [NL];
  int   last_count = 0;
  exp_t exp_q [$];

  assign layer_done = resp_done | man_done;

  mlp_layer_sequencer #(
    .NUM_LAYERS(NL), .TIMEOUT_CYCLES(TO), .CNT_W(CW), .LW(LWT)
  ) dut (
    .clk_x70(clk),
    .reset_x70(rst),
    .start_x70(start),
    .abort_x70(abort),
    .layer_done_x70(layer_done),
    .layer_reset_x70(layer_reset),
    .active_layer_x70(active_layer),
    .busy_x70(busy),
    .done_x70(done),
    .error_x70(error),
    .cycle_count_x70(cycle_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: each layer costs one launch cycle plus its RUN cycles; a layer
  // that never answers (0) or answers too late faults after TO RUN cycles.
  function automatic void model(input int d [NL], output bit fault, output int off);
    fault = 1'b0;
    off   = 0;
    for (int k = 0; k < NL; k++) begin
      off += 1;
      if (d[k] == 0 || d[k] > TO) begin
        fault = 1'b1;
        off  += TO;
        return;
      end
      off += d[k];
    end
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic nwait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Push the model's prediction for an inference whose start is sampled at edge e0.
  task automatic push_exp(input int e0, output int fin);
    bit f;
    int off;
    model(d_cfg, f, off);
    exp_q.push_back('{f, e0 + off, off});
    if (!f) last_count = off;
    fin = e0 + off;
  endtask

  // Called at a negedge; start is sampled on the next posedge.
  task automatic run_one(output int fin);
    push_exp(cyc + 1, fin);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d events outstanding after %0d cycles", exp_q.size(), bound);
      exp_q.delete();
    end
  endtask

  // Layer responder.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NL; k++) begin
        if (layer_reset[k]) begin
          rcnt[k]      = 0;
          resp_done[k] = 1'b0;
        end else begin
          rcnt[k]++;
          if (d_cfg[k] != 0 && rcnt[k] == d_cfg[k]) resp_done[k] = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every done pulse and every error rise.
  initial begin
    bit   prev_err = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done pulse at cycle %0d, count %0d, none expected", cyc, cycle_count);
          end else begin
            e = exp_q.pop_front();
            $display("done  cycle=%0d count=%0d (expected cycle=%0d count=%0d)", cyc, cycle_count, e.edge_c, e.count);
            chk("done_kind", 0, e.is_fault);
            chk("done_cycle", cyc, e.edge_c);
            chk("done_count", cycle_count, e.count);
          end
        end
        if (error && !prev_err) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fault: error rose at cycle %0d, none expected", cyc);
          end else begin
            e = exp_q.pop_front();
            $display("fault cycle=%0d (expected cycle=%0d)", cyc, e.edge_c);
            chk("fault_kind", 1, e.is_fault);
            chk("fault_cycle", cyc, e.edge_c);
            chk("fault_resets", layer_reset, {NL{1'b1}});
            chk("fault_busy", busy, 0);
          end
        end
      end
      prev_err = error;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    int fin;
    int fin2;
    logic [NL-1:0] tr_rst [$];
    int            tr_act [$];
    d_cfg = '{0, 0, 0};

    nwait(3);
    rst = 1'b0;
    nwait(1);
    chk("init_resets", layer_reset, {NL{1'b1}});
    chk("init_active", active_layer, 0);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_error", error, 0);
    chk("init_count", cycle_count, 0);

    // Basic inference with a per-cycle trace of resets and active layer.
    d_cfg = '{4, 4, 4};
    run_one(fin);
    for (int k = 0; k < NL; k++) begin
      tr_rst.push_back({NL{1'b1}});
      tr_act.push_back(k);
      for (int j = 0; j < d_cfg[k]; j++) begin
        tr_rst.push_back(~(NL'(1) << k));
        tr_act.push_back(k);
      end
    end
    for (int i = 0; i < tr_rst.size(); i++) begin
      chk("trace_resets", layer_reset, tr_rst[i]);
      chk("trace_active", active_layer, tr_act[i]);
      chk("trace_busy", busy, 1);
      @(negedge clk);
    end
    drain(50);
    nwait(2);

    // Done on the final watchdog cycle wins; minimum-length inference.
    d_cfg = '{16, 1, 1};
    run_one(fin);
    drain(100);
    nwait(2);
    d_cfg = '{1, 1, 1};
    run_one(fin);
    drain(50);
    nwait(2);

    // Layer 1 never answers, then a new start clears the fault.
    d_cfg = '{3, 0, 3};
    run_one(fin);
    drain(100);
    nwait(3);
    chk("fault_sticky", error, 1);
    d_cfg = '{2, 2, 2};
    run_one(fin);
    chk("restart_error_cleared", error, 0);
    chk("restart_busy", busy, 1);
    @(negedge clk);
    chk("restart_layer0", layer_reset, 3'b110);
    drain(50);
    nwait(2);

    // Queued start during layer 1; a third start during layer 2 is dropped.
    d_cfg = '{3, 3, 3};
    run_one(fin);
    nwait(5);
    push_exp(fin + 1, fin2);
    start = 1'b1;
    nwait(1);
    start = 1'b0;
    nwait(3);
    start = 1'b1;
    nwait(1);
    start = 1'b0;
    drain(200);
    nwait(40);

    // Abort during layer 2 with a start pending.
    start = 1'b1;
    nwait(1);
    start = 1'b0;
    nwait(5);
    start = 1'b1;
    nwait(1);
    start = 1'b0;
    nwait(4);
    abort = 1'b1;
    nwait(1);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_resets", layer_reset, {NL{1'b1}});
    chk("abort_count_held", cycle_count, last_count);
    chk("abort_error", error, 0);
    nwait(40);
    chk("abort_pending_cleared", busy, 0);
    d_cfg = '{2, 2, 2};
    run_one(fin);
    drain(50);
    nwait(30);

    // Done of layer 0 already high at start; stray pulse on layer 2's done.
    d_cfg = '{0, 2, 2};
    man_done[0] = 1'b1;
    nwait(3);
    push_exp(cyc + 1, fin);
    exp_q.delete();
    exp_q.push_back('{1'b0, cyc + 12, 11});
    last_count = 11;
    start = 1'b1;
    nwait(1);
    start = 1'b0;
    nwait(2);
    man_done[2] = 1'b1;
    nwait(1);
    man_done[2] = 1'b0;
    man_done[0] = 1'b0;
    nwait(1);
    man_done[0] = 1'b1;
    drain(50);
    man_done[0] = 1'b0;
    nwait(3);

    // Randomized inferences, some faulting, some at the watchdog limit.
    for (int r = 0; r < 25; r++) begin
      nwait($urandom_range(1, 4));
      for (int k = 0; k < NL; k++) begin
        case ($urandom_range(0, 9))
          0:       d_cfg[k] = 0;
          1:       d_cfg[k] = TO;
          default: d_cfg[k] = $urandom_range(1, 6);
        endcase
      end
      run_one(fin);
      drain(400);
    end
    nwait(3);

    // Asynchronous reset mid-RUN, checked before the next clock edge.
    d_cfg = '{5, 5, 5};
    run_one(fin);
    nwait(8);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_resets", layer_reset, {NL{1'b1}});
    chk("arst_active", active_layer, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_error", error, 0);
    chk("arst_count", cycle_count, 0);
    exp_q.delete();
    last_count = 0;
    nwait(2);
    rst = 1'b0;
    nwait(2);
    d_cfg = '{1, 2, 3};
    run_one(fin);
    drain(50);
    nwait(5);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
